// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: turns one line command into a stream of clipped
// {x, y, colour} pixel words for the framebuffer writer's pixel FIFO.
module line_rasterizer #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] x0,
    input  logic [15:0] y0,
    input  logic [15:0] x1,
    input  logic [15:0] y1,
    input  logic [31:0] colour,
    output logic [63:0] pixel_data,
    output logic        pixel_data_valid,
    input  logic        pixel_fifo_full,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_DRAW,
        ST_DONE
    } state_t;

    localparam logic signed [17:0] STEP_POS = 18'sd1;
    localparam logic signed [17:0] STEP_NEG = -18'sd1;

    state_t state_q, state_d;

    // Index 0 is the x axis, index 1 the y axis.
    logic signed [17:0] start_q [2];
    logic signed [17:0] start_d [2];
    logic signed [17:0] end_q   [2];
    logic signed [17:0] end_d   [2];
    logic signed [17:0] cur_q   [2];
    logic signed [17:0] cur_d   [2];
    logic [1:0]         dir_neg_q, dir_neg_d;
    logic [31:0]        colour_q, colour_d;
    logic signed [17:0] dx_q, dx_d;
    logic signed [17:0] dy_q, dy_d;
    logic signed [17:0] err_q, err_d;

    logic signed [17:0] delta   [2];
    logic signed [17:0] mag     [2];
    logic signed [17:0] stepped [2];
    logic [1:0]         neg_dir;
    logic [1:0]         visible;

    logic               in_bounds;
    logic               at_end;
    logic               consume;
    logic signed [17:0] e2;
    logic               step_x;
    logic               step_y;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            localparam logic signed [17:0] LIM = (gi == 0) ? 18'(SCREEN_W) : 18'(SCREEN_H);

            // 18-bit math keeps |x1-x0| exact for any pair of 16-bit endpoints.
            assign delta[gi]   = end_q[gi] - start_q[gi];
            assign mag[gi]     = delta[gi][17] ? -delta[gi] : delta[gi];
            assign neg_dir[gi] = !(start_q[gi] < end_q[gi]);
            assign visible[gi] = (cur_q[gi] >= 18'sd0) && (cur_q[gi] < LIM);
            assign stepped[gi] = cur_q[gi] + (dir_neg_q[gi] ? STEP_NEG : STEP_POS);
        end
    endgenerate

    assign in_bounds  = &visible;
    assign at_end     = (cur_q[0] == end_q[0]) && (cur_q[1] == end_q[1]);
    assign consume    = !in_bounds || !pixel_fifo_full;
    assign e2         = err_q <<< 1;
    assign step_x     = (e2 >= dy_q);
    assign step_y     = (e2 <= dx_q);
    assign pixel_data = {cur_q[0][15:0], cur_q[1][15:0], colour_q};

    always_comb begin
        state_d          = state_q;
        start_d          = start_q;
        end_d            = end_q;
        cur_d            = cur_q;
        dir_neg_d        = dir_neg_q;
        colour_d         = colour_q;
        dx_d             = dx_q;
        dy_d             = dy_q;
        err_d            = err_q;
        pixel_data_valid = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d    = ST_SETUP;
                    start_d[0] = {{2{x0[15]}}, x0};
                    start_d[1] = {{2{y0[15]}}, y0};
                    end_d[0]   = {{2{x1[15]}}, x1};
                    end_d[1]   = {{2{y1[15]}}, y1};
                    colour_d   = colour;
                end
            end

            ST_SETUP: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    dx_d      = mag[0];
                    dy_d      = -mag[1];
                    err_d     = mag[0] - mag[1];
                    dir_neg_d = neg_dir;
                    cur_d     = start_q;
                    state_d   = ST_DRAW;
                end
            end

            ST_DRAW: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    // Clipped pixels are consumed regardless of FIFO backpressure.
                    pixel_data_valid = in_bounds && !pixel_fifo_full;
                    if (consume) begin
                        if (at_end) begin
                            state_d = ST_DONE;
                        end else begin
                            err_d = err_q + (step_x ? dy_q : 18'sd0) + (step_y ? dx_q : 18'sd0);
                            if (step_x) begin
                                cur_d[0] = stepped[0];
                            end
                            if (step_y) begin
                                cur_d[1] = stepped[1];
                            end
                        end
                    end
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            start_q[0] <= '0;
            start_q[1] <= '0;
            end_q[0]   <= '0;
            end_q[1]   <= '0;
            cur_q[0]   <= '0;
            cur_q[1]   <= '0;
            dir_neg_q  <= '0;
            colour_q   <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            err_q      <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            end_q     <= end_d;
            cur_q     <= cur_d;
            dir_neg_q <= dir_neg_d;
            colour_q  <= colour_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            err_q     <= err_d;
        end
    end

endmodule
